// File: rtl/mips_pkg.sv
// Shared constants and encodings for the iterative multiply/divide unit.
// Holds the default widths, the operation codes and the sequencer states.
package mips_pkg;

  localparam int XLEN = 32;
  localparam int ITER = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage handshake and HI/LO bus between the pipeline and the multiply/divide unit.
// The pipeline side uses the master modport; the unit uses the slave modport.
interface muldiv_unit_if import mips_pkg::*; #(
  parameter int XLEN = mips_pkg::XLEN
);
  logic            StartE;
  logic [1:0]      OpE;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic            WeHiE;
  logic            WeLoE;
  logic [XLEN-1:0] WdataE;
  logic            HiLoAccessD;
  logic [XLEN-1:0] Hi;
  logic [XLEN-1:0] Lo;
  logic            Busy;
  logic            StallD;

  modport master (
    output StartE, OpE, SrcAE, SrcBE, WeHiE, WeLoE, WdataE, HiLoAccessD,
    input  Hi, Lo, Busy, StallD
  );

  modport slave (
    input  StartE, OpE, SrcAE, SrcBE, WeHiE, WeLoE, WdataE, HiLoAccessD,
    output Hi, Lo, Busy, StallD
  );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: shift-add for multiply, restoring
// shift-subtract for divide. {hi,lo} is the running accumulator.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt
);
  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    hi_nxt  = hi;
    lo_nxt  = lo;
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    shifted = {hi, lo[XLEN-1]};
    // Partial remainder stays below the divisor, so bit XLEN of diff is a true borrow.
    diff    = shifted - {1'b0, opnd};
    if (is_div) begin
      if (!diff[XLEN]) begin
        hi_nxt = diff[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt = shifted[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_nxt = sum[XLEN:1];
      lo_nxt = {sum[0], lo[XLEN-1:1]};
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style multiply/divide unit owning the architectural HI/LO registers.
// Operates on magnitudes for ITER cycles, then applies sign correction in one fix-up cycle.
module muldiv_unit import mips_pkg::*; #(
  parameter int XLEN = mips_pkg::XLEN,
  parameter int ITER = mips_pkg::ITER
) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave bus
);
  localparam int             CW       = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0]  CNT_LOAD = CW'(ITER - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic            is_div_q, is_div_d, neg_res_q, neg_res_d;
  logic            neg_rem_q, neg_rem_d, div_zero_q, div_zero_d;

  logic [XLEN-1:0]   step_hi, step_lo, mag_a, mag_b, quo_fix, rem_fix;
  logic [2*XLEN-1:0] prod_fix;
  logic              signed_op, sgn_a, sgn_b;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div (is_div_q),
    .hi     (acc_hi_q),
    .lo     (acc_lo_q),
    .opnd   (opnd_q),
    .hi_nxt (step_hi),
    .lo_nxt (step_lo)
  );

  always_comb begin
    signed_op = (bus.OpE == OP_MULT) || (bus.OpE == OP_DIV);
    sgn_a     = signed_op & bus.SrcAE[XLEN-1];
    sgn_b     = signed_op & bus.SrcBE[XLEN-1];
    mag_a     = sgn_a ? -bus.SrcAE : bus.SrcAE;
    mag_b     = sgn_b ? -bus.SrcBE : bus.SrcBE;
    prod_fix  = neg_res_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    // Divide by zero: remainder already equals the dividend, quotient is forced to all ones.
    quo_fix   = div_zero_q ? '1 : (neg_res_q ? -acc_lo_q : acc_lo_q);
    rem_fix   = neg_rem_q ? -acc_hi_q : acc_hi_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    opnd_d     = opnd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.StartE) begin
          state_d    = ST_RUN;
          cnt_d      = CNT_LOAD;
          is_div_d   = (bus.OpE == OP_DIV) || (bus.OpE == OP_DIVU);
          acc_hi_d   = '0;
          acc_lo_d   = mag_a;
          opnd_d     = mag_b;
          neg_res_d  = sgn_a ^ sgn_b;
          neg_rem_d  = sgn_a;
          div_zero_d = is_div_d && (bus.SrcBE == '0);
        end else begin
          if (bus.WeHiE) hi_d = bus.WdataE;
          if (bus.WeLoE) lo_d = bus.WdataE;
        end
      end
      ST_RUN: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      opnd_q     <= opnd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.Hi     = hi_q;
  assign bus.Lo     = lo_q;
  assign bus.Busy   = (state_q != ST_IDLE);
  assign bus.StallD = bus.Busy & bus.HiLoAccessD;
endmodule
